// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces a raw push-button pin into a
// clean level (btn_level), with a busy flag while a candidate edge qualifies.
// Optional auto-repeat strobe for held buttons: define BUTTON_DEBOUNCER_REPEAT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------
// S_IDLE      | stable released, btn_level = 0
// S_PRESS_CHK | candidate press, counting stable-1 cycles
// S_HELD      | stable pressed, btn_level = 1
// S_REL_CHK   | candidate release, counting stable-0 cycles
module button_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int ACTIVE_LOW_IN   = 0,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_busy,
   output logic repeat_pulse
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic            IN_INV  = (ACTIVE_LOW_IN != 0);

   // Elaboration-time guard on the legal parameter ranges.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("button_debouncer: illegal parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PRESS_CHK = 2'd1,
      S_HELD      = 2'd2,
      S_REL_CHK   = 2'd3
   } state_t;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   // Synchronizer chain; reset forces the not-pressed value regardless of the pin.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in ^ IN_INV};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Next-state and stability-counter logic; counter clears on every state change.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_IDLE: begin
            if (s) begin
               state_n = S_PRESS_CHK;
               cnt_n   = '0;
            end
         end
         S_PRESS_CHK: begin
            if (!s) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else if (cnt == CNT_MAX) begin
               state_n = S_HELD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_HELD: begin
            if (!s) begin
               state_n = S_REL_CHK;
               cnt_n   = '0;
            end
         end
         S_REL_CHK: begin
            if (s) begin
               state_n = S_HELD;
               cnt_n   = '0;
            end else if (cnt == CNT_MAX) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // State register with registered level and busy outputs derived from next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_busy  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         btn_level <= (state_n == S_HELD) || (state_n == S_REL_CHK);
         btn_busy  <= (state_n == S_PRESS_CHK) || (state_n == S_REL_CHK);
      end
   end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_first_done;
   logic             rpt_q;
   logic             stay_held;
   logic [RPT_W-1:0] rpt_target;

   // The cycle that enters S_HELD is not a "stay", so the rising edge never pulses.
   assign stay_held  = (state == S_HELD) && (state_n == S_HELD);
   assign rpt_target = rpt_first_done ? RPT_NEXT : RPT_FIRST;

   // Repeat timer: runs only while held, restarts from the initial delay on any exit.
   always_ff @(posedge clk) begin
      if (!reset || !stay_held) begin
         rpt_cnt        <= '0;
         rpt_first_done <= 1'b0;
         rpt_q          <= 1'b0;
      end else if (rpt_cnt == rpt_target) begin
         rpt_cnt        <= '0;
         rpt_first_done <= 1'b1;
         rpt_q          <= 1'b1;
      end else begin
         rpt_cnt <= rpt_cnt + RPT_W'(1);
         rpt_q   <= 1'b0;
      end
   end

   assign repeat_pulse = rpt_q;
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw, bouncing push-button input (board button for lens-filter mode select) into a clean, glitch-free level.
- Sits directly upstream of the edge detector, which turns btn_level into single-cycle press/release strobes for the filter-mode control logic.
- Contains a double-flop synchronizer, a stability counter and a 4-state FSM.
- An optional auto-repeat strobe is available for held buttons.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on btn_in (legal range 2..4).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); minimum 2.
- ACTIVE_LOW_IN, 0, when 1 the raw input is inverted before synchronization (pressed = 0 on pin).
- REPEAT_DELAY, 50_000_000, cycles of held state before the first repeat strobe (used only with the optional feature).
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat strobes (used only with the optional feature).

Ports:
- clk  input  1  system clock; the block has one clock; reset is synchronous and active-low.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- btn_in  input  1  raw asynchronous button pin.
- btn_level  output  1  debounced level, 1 = pressed.
- btn_busy  output  1  1 while a candidate transition is being qualified.
- repeat_pulse  output  1  single-cycle auto-repeat strobe; constant 0 without the optional feature.

Behaviour:
- Reset (reset=0 at a rising clk):
  - All sync flops cleared to the "not pressed" value (0 after the optional inversion); this does not depend on the pin.
  - Counter = 0, FSM = S_IDLE.
  - btn_level=0, btn_busy=0, repeat_pulse=0.
  - Reset asserted mid-qualification or while held aborts immediately. No strobe or level change is produced on reset exit until a full re-qualification completes.
- Synchronizer: s = last stage of the SYNC_STAGES flop chain.
- FSM states: S_IDLE (level 0), S_PRESS_CHK (candidate 1), S_HELD (level 1), S_REL_CHK (candidate 0).
- S_IDLE:
  - s=1 → S_PRESS_CHK, cnt<=0.
- S_PRESS_CHK:
  - s=0 → S_IDLE, cnt<=0 (glitch rejected; btn_level unchanged).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 → S_HELD, btn_level<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- S_HELD:
  - s=0 → S_REL_CHK, cnt<=0.
- S_REL_CHK: mirror of S_PRESS_CHK.
  - s=1 → S_HELD.
  - Stable 0 for DEBOUNCE_CYCLES → S_IDLE, btn_level<=0.
- Latency: btn_in stable from sampling edge k gives btn_level changing at edge k+SYNC_STAGES+DEBOUNCE_CYCLES. This is the same for press and release.
- Any bounce inside the window restarts qualification from the opposite stable state. btn_level never toggles more than once per accepted transition.
- btn_busy = 1 exactly when FSM is in S_PRESS_CHK or S_REL_CHK (registered with state).
- Counter width: $clog2(DEBOUNCE_CYCLES); it must never wrap, because it is cleared on every state change.
- btn_level is a direct flop output with no combinational path from btn_in.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_REPEAT_EN.
- Defined:
  - A separate repeat counter runs only in S_HELD.
  - The first repeat_pulse (1 cycle) fires REPEAT_DELAY cycles after entering S_HELD; subsequent pulses fire every REPEAT_PERIOD cycles.
  - Leaving S_HELD (including entry to S_REL_CHK) or reset clears the counter. A bounce that returns to S_HELD restarts from REPEAT_DELAY.
  - No pulse is generated on the cycle btn_level rises; the downstream edge detector supplies the press strobe.
- Undefined: repeat counter logic is absent, repeat_pulse tied to 0.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset release with btn_in=1 held → btn_level=0 through reset; rises exactly 6 cycles after the first post-reset sampling edge; btn_busy=1 for 4 cycles before.
- Clean press then release (btn_in 0→1, held 20 cycles, 1→0) → btn_level rises 6 cycles after the press and falls 6 cycles after the release; exactly one rise and one fall.
- Bounce: btn_in 1 for 3 cycles, 0 for 2, then 1 steady → no btn_level change during the bounce; rise occurs 6 cycles after the final 0→1.
- Release glitch: in S_HELD, btn_in 0 for 2 cycles then 1 → btn_level stays 1; btn_busy pulses high for 2 cycles and returns to 0.
- Reset mid-qualification: reset=0 on the 2nd counting cycle of a press, then released with btn_in=1 → btn_level stays 0 and rises 6 cycles after reset release.
- With BUTTON_DEBOUNCER_REPEAT_EN defined, hold the button for 50 cycles after btn_level rises → repeat_pulse at offsets 20, 28, 36, 44, each 1 cycle wide. Without the macro, repeat_pulse=0 throughout.
